// File: rtl/round_pkg.sv
// Shared state codes for the round controller, ready block and display.
package round_pkg;

  localparam int STATE_W = 4;

  localparam logic [STATE_W-1:0] ST_IDLE   = 4'b0000;
  localparam logic [STATE_W-1:0] ST_FETCH  = 4'b0010;
  localparam logic [STATE_W-1:0] ST_ANSWER = 4'b0011;
  localparam logic [STATE_W-1:0] ST_LOCK   = 4'b0100;
  localparam logic [STATE_W-1:0] ST_DRAW   = 4'b0110;
  localparam logic [STATE_W-1:0] ST_GOOD   = 4'b1000;
  localparam logic [STATE_W-1:0] ST_OUCH   = 4'b1001;
  localparam logic [STATE_W-1:0] ST_WIN    = 4'b1010;
  localparam logic [STATE_W-1:0] ST_LOSE   = 4'b1011;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = ST_IDLE,
    S_FETCH  = ST_FETCH,
    S_ANSWER = ST_ANSWER,
    S_LOCK   = ST_LOCK,
    S_DRAW   = ST_DRAW,
    S_GOOD   = ST_GOOD,
    S_OUCH   = ST_OUCH,
    S_WIN    = ST_WIN,
    S_LOSE   = ST_LOSE
  } round_state_e;

endpackage

// File: rtl/round_ctrl_sec_tick.sv
// One-second tick generator: counts CLK_PER_SEC enabled clocks, pulses tick on the last one.
module sec_tick #(
  parameter int CLK_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] TC = CNT_W'(CLK_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // tick must not depend on clr: clr is derived from the FSM's next state, which uses tick
  assign tick = en && (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || !en || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/round_ctrl.sv
// Per-player round controller: start detect, DB fetch, timed answer window, judging and score.
// Optional macro ROUND_CTRL_LOCKOUT_EN: a wrong answer locks the player out for 1 s instead of losing the round.
//   state  | meaning
//   IDLE   | waiting for OK rising edge
//   FETCH  | Q_REQ issued, waiting for DB_VALID
//   ANSWER | answer window running, SEC_LEFT counts down
//   LOCK   | wrong-answer lockout (macro build only)
//   GOOD   | own correct answer, holding result
//   OUCH   | wrong answer or opponent first, holding result
//   DRAW   | window expired, holding result
//   WIN    | match won, terminal
//   LOSE   | opponent won match, terminal
module round_ctrl
  import round_pkg::*;
#(
  parameter int CLK_PER_SEC = 50_000_000,
  parameter int ANS_SEC     = 5,
  parameter int RESULT_SEC  = 2,
  parameter int WIN_POINTS  = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               OK,
  input  logic [3:0]         NUM,
  output logic [3:0]         Q_IDX,
  output logic               Q_REQ,
  input  logic               DB_VALID,
  input  logic [3:0]         DB_ANS,
  input  logic               ANS_STB,
  input  logic [3:0]         ANS_VAL,
  input  logic               OPP_HIT,
  output logic               HIT_OUT,
  output logic [STATE_W-1:0] STATE,
  output logic [3:0]         SEC_LEFT,
  output logic [2:0]         SCORE
);

  localparam logic [3:0] ANS_S = 4'(ANS_SEC);
  localparam logic [3:0] RES_S = 4'(RESULT_SEC);
  localparam logic [2:0] WIN_P = 3'(WIN_POINTS);

  round_state_e state_q, state_d;
  logic       ok_q;
  logic [3:0] q_idx_q, q_idx_d;
  logic       q_req_q, q_req_d;
  logic       hit_q, hit_d;
  logic [3:0] ans_q, ans_d;
  logic [3:0] sec_q, sec_d;
  logic [2:0] score_q, score_d;
  logic [2:0] opp_q, opp_d;
  logic       tick, tick_en, tick_clr, own_ok;

  assign tick_en  = (state_q == S_ANSWER) || (state_q == S_LOCK) || (state_q == S_GOOD) ||
                    (state_q == S_OUCH)   || (state_q == S_DRAW);
  assign tick_clr = (state_d != state_q);
  assign own_ok   = ANS_STB && (ANS_VAL == ans_q);

  sec_tick #(.CLK_PER_SEC(CLK_PER_SEC)) u_sec_tick (
    .clk   (CLK),
    .rst_n (RST),
    .en    (tick_en),
    .clr   (tick_clr),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    q_idx_d = q_idx_q;
    q_req_d = 1'b0;
    hit_d   = 1'b0;
    ans_d   = ans_q;
    sec_d   = sec_q;
    score_d = score_q;
    opp_d   = opp_q;
    case (state_q)
      S_IDLE: begin
        if (OK && !ok_q) begin
          q_idx_d = NUM;
          q_req_d = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (DB_VALID) begin
          ans_d   = DB_ANS;
          sec_d   = ANS_S;
          state_d = S_ANSWER;
        end
      end
      S_ANSWER, S_LOCK: begin
        // opponent's hits are tallied even when we win the same cycle: both players score
        if (OPP_HIT && (opp_q != WIN_P)) opp_d = opp_q + 3'd1;
        if ((state_q == S_ANSWER) && own_ok) begin
          hit_d   = 1'b1;
          if (score_q != WIN_P) score_d = score_q + 3'd1;
          sec_d   = RES_S;
          state_d = S_GOOD;
        end else if (OPP_HIT) begin
          sec_d   = RES_S;
          state_d = S_OUCH;
        end else if ((state_q == S_ANSWER) && ANS_STB) begin
`ifdef ROUND_CTRL_LOCKOUT_EN
          state_d = S_LOCK;
`else
          sec_d   = RES_S;
          state_d = S_OUCH;
`endif
        end else if (tick) begin
          if (sec_q == 4'd1) begin
            sec_d   = RES_S;
            state_d = S_DRAW;
          end else begin
            sec_d = sec_q - 4'd1;
            if (state_q == S_LOCK) state_d = S_ANSWER;
          end
        end
      end
      S_GOOD, S_OUCH, S_DRAW: begin
        if (tick) begin
          if (sec_q == 4'd1) begin
            if (score_q == WIN_P)    state_d = S_WIN;
            else if (opp_q == WIN_P) state_d = S_LOSE;
            else                     state_d = S_IDLE;
          end else begin
            sec_d = sec_q - 4'd1;
          end
        end
      end
      S_WIN, S_LOSE: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      ok_q    <= 1'b0;
      q_idx_q <= '0;
      q_req_q <= 1'b0;
      hit_q   <= 1'b0;
      ans_q   <= '0;
      sec_q   <= '0;
      score_q <= '0;
      opp_q   <= '0;
    end else begin
      state_q <= state_d;
      ok_q    <= OK;
      q_idx_q <= q_idx_d;
      q_req_q <= q_req_d;
      hit_q   <= hit_d;
      ans_q   <= ans_d;
      sec_q   <= sec_d;
      score_q <= score_d;
      opp_q   <= opp_d;
    end
  end

  assign STATE    = state_q;
  assign Q_IDX    = q_idx_q;
  assign Q_REQ    = q_req_q;
  assign HIT_OUT  = hit_q;
  assign SCORE    = score_q;
  assign SEC_LEFT = ((state_q == S_ANSWER) || (state_q == S_LOCK)) ? sec_q : 4'd0;

endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl with short timing (10 clk/s, 3 s window, 1 s result, 2 wins).
module tb_round_ctrl;

  logic       CLK, RST, OK, DB_VALID, ANS_STB, OPP_HIT;
  logic [3:0] NUM, DB_ANS, ANS_VAL, Q_IDX, STATE, SEC_LEFT;
  logic       Q_REQ, HIT_OUT;
  logic [2:0] SCORE;

  int n_vec = 0;
  int n_err = 0;

  round_ctrl #(.CLK_PER_SEC(10), .ANS_SEC(3), .RESULT_SEC(1), .WIN_POINTS(2)) dut (
    .CLK(CLK), .RST(RST), .OK(OK), .NUM(NUM), .Q_IDX(Q_IDX), .Q_REQ(Q_REQ),
    .DB_VALID(DB_VALID), .DB_ANS(DB_ANS), .ANS_STB(ANS_STB), .ANS_VAL(ANS_VAL),
    .OPP_HIT(OPP_HIT), .HIT_OUT(HIT_OUT), .STATE(STATE), .SEC_LEFT(SEC_LEFT), .SCORE(SCORE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_round(input logic [3:0] num, input logic [3:0] dbans);
    OK = 1'b0;
    step();
    OK = 1'b1;
    NUM = num;
    step();
    check("fetch_state", STATE, 4'b0010);
    check("q_req_pulse", Q_REQ, 1);
    check("q_idx", Q_IDX, num);
    step();
    check("q_req_done", Q_REQ, 0);
    DB_VALID = 1'b1;
    DB_ANS = dbans;
    step();
    DB_VALID = 1'b0;
    check("answer_state", STATE, 4'b0011);
    check("sec_left_init", SEC_LEFT, 3);
  endtask

  task automatic answer(input logic [3:0] val);
    ANS_STB = 1'b1;
    ANS_VAL = val;
    step();
    ANS_STB = 1'b0;
  endtask

  task automatic opp_hit();
    OPP_HIT = 1'b1;
    step();
    OPP_HIT = 1'b0;
  endtask

  // result state entered 'already' cycles ago; it lasts 10 clocks in total
  task automatic hold(input logic [3:0] res, input logic [3:0] nxt, input int already);
    repeat (9 - already) step();
    check("result_hold", STATE, res);
    step();
    check("result_exit", STATE, nxt);
  endtask

  task automatic sync_reset();
    RST = 1'b0;
    OK = 1'b0;
    step();
    RST = 1'b1;
    check("rst_state", STATE, 0);
    check("rst_score", SCORE, 0);
  endtask

  initial begin
    RST = 1'b0; OK = 1'b0; NUM = '0; DB_VALID = 1'b0; DB_ANS = '0;
    ANS_STB = 1'b0; ANS_VAL = '0; OPP_HIT = 1'b0;
    step();
    step();
    check("rst_state", STATE, 0);
    check("rst_q_idx", Q_IDX, 0);
    check("rst_q_req", Q_REQ, 0);
    check("rst_hit", HIT_OUT, 0);
    check("rst_sec", SEC_LEFT, 0);
    check("rst_score", SCORE, 0);
    RST = 1'b1;

    // correct answer, OK left high afterwards
    start_round(4'd7, 4'd6);
    answer(4'd6);
    check("good_state", STATE, 4'b1000);
    check("hit_out", HIT_OUT, 1);
    check("score_1", SCORE, 1);
    step();
    check("hit_one_cycle", HIT_OUT, 0);
    hold(4'b1000, 4'b0000, 1);
    repeat (5) step();
    check("ok_held_idle", STATE, 0);

    // wrong answer
    start_round(4'd3, 4'd9);
    answer(4'd5);
    check("ouch_wrong", STATE, 4'b1001);
    check("wrong_no_hit", HIT_OUT, 0);
    check("wrong_score", SCORE, 1);
    hold(4'b1001, 4'b0000, 0);

    // timeout, out-of-range NUM accepted
    start_round(4'd12, 4'd4);
    repeat (9) step();
    check("sec_3", SEC_LEFT, 3);
    step();
    check("sec_2", SEC_LEFT, 2);
    repeat (10) step();
    check("sec_1", SEC_LEFT, 1);
    repeat (9) step();
    check("pre_timeout", STATE, 4'b0011);
    step();
    check("draw_state", STATE, 4'b0110);
    check("draw_sec", SEC_LEFT, 0);
    check("draw_score", SCORE, 1);
    hold(4'b0110, 4'b0000, 0);

    // opponent wins two rounds -> LOSE
    start_round(4'd1, 4'd1);
    opp_hit();
    check("opp_ouch1", STATE, 4'b1001);
    check("opp_score1", SCORE, 1);
    hold(4'b1001, 4'b0000, 0);
    start_round(4'd2, 4'd2);
    opp_hit();
    check("opp_ouch2", STATE, 4'b1001);
    hold(4'b1001, 4'b1011, 0);
    OK = 1'b0;
    repeat (10) step();
    OK = 1'b1;
    repeat (10) step();
    check("lose_held", STATE, 4'b1011);

    // same-cycle own correct and opponent hit -> own GOOD
    sync_reset();
    start_round(4'd5, 4'd8);
    ANS_STB = 1'b1; ANS_VAL = 4'd8; OPP_HIT = 1'b1;
    step();
    ANS_STB = 1'b0; OPP_HIT = 1'b0;
    check("tie_good", STATE, 4'b1000);
    check("tie_hit", HIT_OUT, 1);
    check("tie_score", SCORE, 1);
    hold(4'b1000, 4'b0000, 0);

    // asynchronous reset mid-ANSWER
    start_round(4'd6, 4'd3);
    repeat (3) step();
    #3 RST = 1'b0;
    #1;
    check("arst_state", STATE, 0);
    check("arst_q_idx", Q_IDX, 0);
    check("arst_q_req", Q_REQ, 0);
    check("arst_hit", HIT_OUT, 0);
    check("arst_sec", SEC_LEFT, 0);
    check("arst_score", SCORE, 0);
    OK = 1'b0;
    step();
    RST = 1'b1;

    // two wins -> WIN
    start_round(4'd4, 4'd4);
    answer(4'd4);
    check("win1_score", SCORE, 1);
    hold(4'b1000, 4'b0000, 0);
    start_round(4'd9, 4'd0);
    answer(4'd0);
    check("win2_score", SCORE, 2);
    hold(4'b1000, 4'b1010, 0);
    repeat (20) step();
    check("win_held", STATE, 4'b1010);
    check("win_score", SCORE, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
